// File: rtl/dmem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_pkg
//   Shared definitions for the data-memory controller: MIPS load/store opcode
//   constants, FSM state encoding and small helpers for store lane placement
//   and alignment checks.
//
//   Configuration macro: DMEM_MISALIGN_EXC_EN (consumed by dmem_ctrl; the
//   helpers here are build-independent).
// -----------------------------------------------------------------------------
package dmem_ctrl_pkg;

  // MIPS I-type opcodes for the memory instructions.
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Halfwords must sit on even addresses, words on multiples of four.
  function automatic logic access_misaligned(input logic [5:0] op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lo[0];
      OP_LW, OP_SW:         return lo != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  // Byte write enables for a store. Halfwords select their half with addr[1]
  // only, so a stray addr[0] never splits a halfword across lanes.
  function automatic logic [3:0] store_be(input logic [5:0] op, input logic [1:0] lo);
    case (op)
      OP_SB:   return 4'b0001 << lo;
      OP_SH:   return lo[1] ? 4'b1100 : 4'b0011;
      OP_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data into every lane it could land in; the
  // byte enables pick the lane, so no shifter is needed.
  function automatic logic [31:0] store_lanes(input logic [5:0] op, input logic [31:0] w);
    case (op)
      OP_SB:   return {4{w[7:0]}};
      OP_SH:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_ld_extract.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_ld_extract
//   Purely combinational load formatter: picks the addressed byte/halfword out
//   of an SRAM word and zero- or sign-extends it to 32 bits.
//
//   Ports:
//     op_i    [5:0]  load opcode (lb/lh/lw/lbu/lhu; anything else passes through)
//     lane_i  [1:0]  byte address bits [1:0]
//     word_i  [31:0] raw SRAM word
//     data_o  [31:0] extended, right-aligned load result
// -----------------------------------------------------------------------------
module dmem_ctrl_ld_extract
  import dmem_ctrl_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave a latch behind.
    byte_sel = word_i[7:0];
    case (lane_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase

    // Halfword lane follows addr[1] only; addr[0] is don't-care here.
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = word_i;
    case (op_i)
      OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data_o = {24'h0, byte_sel};
      OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//   Data-memory responder for the MEM-stage load/store interface. Accepts one
//   request at a time, drives a single-port synchronous SRAM with per-byte
//   write enables and returns lane-extracted, extended load data.
//
//   Ports:
//     clk, rst          clock (rising edge), asynchronous active-high reset
//     req_i             request valid, sampled only while ready_o=1
//     op_i [5:0]        MIPS opcode (lb/lh/lw/lbu/lhu/sb/sh/sw)
//     addr_i [31:0]     byte address
//     wdata_i [31:0]    right-aligned store data
//     ready_o           controller idle, a request will be accepted
//     done_o            one-cycle completion pulse
//     rdata_o [31:0]    extended load result, held until the next load completes
//     exc_o             misaligned-access flag, valid with done_o
//     badaddr_o [31:0]  address of the last misaligned request
//     ram_en_o          SRAM cycle enable
//     ram_be_o [3:0]    byte write enables, 0 means read
//     ram_addr_o        SRAM word address
//     ram_wdata_o       lane-placed store data
//     ram_rdata_i       SRAM read data, valid the cycle after a read cycle
//
//   Configuration macro DMEM_MISALIGN_EXC_EN: when defined, misaligned
//   halfword/word requests complete without touching the SRAM and raise exc_o
//   with badaddr_o. When undefined, exc_o/badaddr_o are tied low and the low
//   address bits a halfword/word access does not need are ignored.
// -----------------------------------------------------------------------------
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [5:0]        op_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              exc_o,
  output logic [31:0]       badaddr_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_be_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  state_e            state_q;
  logic [5:0]        op_q;
  logic [1:0]        lane_q;
  logic              done_q;
  logic [31:0]       rdata_q;
  logic              ram_en_q;
  logic [3:0]        ram_be_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       ram_wdata_q;

  logic              accept_d;
  logic              misaligned_d;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;
  logic [31:0]       ld_data_d;

  // Address bits above the SRAM range never select anything.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:ADDR_W+2];

  assign accept_d = req_i && (state_q == ST_IDLE);
  assign be_d     = store_be(op_i, addr_i[1:0]);
  assign wdata_d  = store_lanes(op_i, wdata_i);

  dmem_ctrl_ld_extract u_ld_extract (
    .op_i   (op_q),
    .lane_i (lane_q),
    .word_i (ram_rdata_i),
    .data_o (ld_data_d)
  );

`ifdef DMEM_MISALIGN_EXC_EN
  logic        exc_q;
  logic [31:0] badaddr_q;

  assign misaligned_d = access_misaligned(op_i, addr_i[1:0]);

  // A rejected misaligned request completes on the cycle after acceptance,
  // the same cycle the FSM raises done_q for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_q     <= 1'b0;
      badaddr_q <= 32'h0;
    end else begin
      exc_q <= accept_d && misaligned_d;
      if (accept_d && misaligned_d) badaddr_q <= addr_i;
    end
  end

  assign exc_o     = exc_q;
  assign badaddr_o = badaddr_q;
`else
  assign misaligned_d = 1'b0;
  assign exc_o        = 1'b0;
  assign badaddr_o    = 32'h0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 6'h0;
      lane_q      <= 2'b00;
      done_q      <= 1'b0;
      rdata_q     <= 32'h0;
      ram_en_q    <= 1'b0;
      ram_be_q    <= 4'h0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      // Pulses and SRAM strobes default low; each state raises what it needs.
      done_q   <= 1'b0;
      ram_en_q <= 1'b0;
      ram_be_q <= 4'h0;

      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            op_q   <= op_i;
            lane_q <= addr_i[1:0];
            if (is_store(op_i) && !misaligned_d) begin
              state_q     <= ST_WR;
              ram_en_q    <= 1'b1;
              ram_be_q    <= be_d;
              ram_addr_q  <= addr_i[ADDR_W+1:2];
              ram_wdata_q <= wdata_d;
            end else if (is_load(op_i) && !misaligned_d) begin
              state_q    <= ST_RD;
              ram_en_q   <= 1'b1;
              ram_addr_q <= addr_i[ADDR_W+1:2];
            end else begin
              // Unknown opcode or rejected misaligned access: complete
              // immediately, the SRAM is never touched.
              done_q <= 1'b1;
            end
          end
        end

        ST_WR: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end

        ST_RD: begin
          // The SRAM captured the read at this edge; its data appears next cycle.
          state_q <= ST_RSP;
        end

        ST_RSP: begin
          state_q <= ST_IDLE;
          rdata_q <= ld_data_d;
          done_q  <= 1'b1;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o     = (state_q == ST_IDLE);
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign ram_en_o    = ram_en_q;
  assign ram_be_o    = ram_be_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
//   Self-checking bench for dmem_ctrl. A byte-addressed reference memory and a
//   transaction-level timing model predict, per cycle, ready/done/exc/rdata/
//   badaddr and the SRAM strobes. Directed scenarios are pinned with literal
//   values, then randomized traffic runs against the same model. Builds with
//   or without DMEM_MISALIGN_EXC_EN.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int ADDR_W = 12;
  localparam int NWORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_i = 1'b0;
  logic [5:0]        op_i = 6'h0;
  logic [31:0]       addr_i = 32'h0;
  logic [31:0]       wdata_i = 32'h0;
  logic              ready_o, done_o, exc_o, ram_en_o;
  logic [31:0]       rdata_o, badaddr_o, ram_wdata_o;
  logic [3:0]        ram_be_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_rdata_i = 32'h0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .op_i        (op_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .exc_o       (exc_o),
    .badaddr_o   (badaddr_o),
    .ram_en_o    (ram_en_o),
    .ram_be_o    (ram_be_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i)
  );

  // ---------------- SRAM environment ----------------
  logic [31:0] sram [NWORDS];

  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_be_o == 4'h0) ram_rdata_i <= sram[ram_addr_o];
      else for (int i = 0; i < 4; i++)
        if (ram_be_o[i]) sram[ram_addr_o][8*i +: 8] <= ram_wdata_o[8*i +: 8];
    end
  end

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] mem_ref [NWORDS*4];

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          rst_in_rd;
  } stim_t;

  typedef struct {
    stim_t             s;
    int                acc;
    int                done_cyc;
    bit                uses_ram;
    bit                is_st;
    bit                is_ld;
    bit                exp_exc;
    logic [3:0]        exp_be;
    logic [31:0]       exp_wdata;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       exp_rdata;
    bit                obs_en;
    logic [3:0]        obs_be;
    logic [ADDR_W-1:0] obs_addr;
    logic [31:0]       obs_wdata;
    logic [31:0]       obs_rdata;
    logic              obs_exc;
    logic [31:0]       obs_bad;
    int                obs_done;
  } rec_t;

  stim_t       stim_q[$];
  rec_t        log_q[$];
  rec_t        cur;
  bit          cur_valid = 1'b0;
  bit          run = 1'b0;
  bit          gaps = 1'b0;
  int          rst_check = 0;
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] last_bad = 32'h0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Predicts one accepted request from the architectural rules: access size,
  // effective (size-aligned) byte address and little-endian byte order.
  function automatic rec_t model_accept(input stim_t s, input int acc);
    rec_t              r;
    int                size;
    bit                sgn;
    bit                mis;
    logic [ADDR_W+1:0] ba_l;
    int                ba, ea;
    logic [31:0]       v;
    r = '{default: 0};
    r.s = s;
    r.acc = acc;
    r.obs_done = -1;
    r.exp_addr = s.addr[ADDR_W+1:2];
    r.exp_be = 4'h0;
    case (s.op)
      OP_LB, OP_LBU, OP_SB: size = 1;
      OP_LH, OP_LHU, OP_SH: size = 2;
      OP_LW, OP_SW:         size = 4;
      default:              size = 0;
    endcase
    sgn = (s.op == OP_LB) || (s.op == OP_LH);
    r.is_ld = s.op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    r.is_st = s.op inside {OP_SB, OP_SH, OP_SW};
    ba_l = s.addr[ADDR_W+1:0];
    ba = int'(ba_l);
`ifdef DMEM_MISALIGN_EXC_EN
    mis = (size > 1) && (ba % size != 0);
`else
    mis = 1'b0;
`endif
    ea = (size > 0) ? ba - (ba % size) : ba;
    if (size == 0 || mis) begin
      r.uses_ram = 1'b0;
      r.done_cyc = acc;
      r.exp_exc  = mis;
      r.is_ld    = 1'b0;
      r.is_st    = 1'b0;
    end else if (r.is_st) begin
      r.uses_ram = 1'b1;
      r.done_cyc = acc + 1;
      for (int k = 0; k < size; k++) begin
        r.exp_be[(ea + k) % 4] = 1'b1;
        mem_ref[ea + k] = s.wdata[8*k +: 8];
      end
      r.exp_wdata = (size == 1) ? {4{s.wdata[7:0]}} :
                    (size == 2) ? {2{s.wdata[15:0]}} : s.wdata;
    end else begin
      r.uses_ram = 1'b1;
      r.done_cyc = acc + 2;
      v = 32'h0;
      for (int k = 0; k < size; k++) v[8*k +: 8] = mem_ref[ea + k];
      if (sgn && size == 1) v = {{24{v[7]}}, v[7:0]};
      if (sgn && size == 2) v = {{16{v[15]}}, v[15:0]};
      r.exp_rdata = v;
    end
    return r;
  endfunction

  // ---------------- per-cycle compare + driver ----------------
  always @(negedge clk) begin : cmp
    stim_t s;
    bit    exp_ready, exp_done, exp_en;
    if (run) begin
      if (rst_check == 1) begin
        check("rst_ram_en", 32'(ram_en_o), 32'd0);
        check("rst_ram_be", 32'(ram_be_o), 32'd0);
        check("rst_done",   32'(done_o),   32'd0);
        check("rst_ready",  32'(ready_o),  32'd1);
        check("rst_rdata",  rdata_o,       32'h0);
        check("rst_badaddr", badaddr_o,    32'h0);
        rst = 1'b0;
        rst_check = 0;
        last_rdata = 32'h0;
        last_bad = 32'h0;
      end else begin
        exp_ready = !(cur_valid && cyc < cur.done_cyc);
        exp_done  = cur_valid && cyc == cur.done_cyc;
        exp_en    = cur_valid && cur.uses_ram && cyc == cur.acc;
        check("ready",  32'(ready_o),  32'(exp_ready));
        check("done",   32'(done_o),   32'(exp_done));
        check("ram_en", 32'(ram_en_o), 32'(exp_en));
        check("ram_be", 32'(ram_be_o), exp_en ? 32'(cur.exp_be) : 32'd0);
        if (exp_en) begin
          cur.obs_en = 1'b1;
          cur.obs_be = ram_be_o;
          cur.obs_addr = ram_addr_o;
          cur.obs_wdata = ram_wdata_o;
          check("ram_addr", 32'(ram_addr_o), 32'(cur.exp_addr));
          if (cur.is_st) check("ram_wdata", ram_wdata_o, cur.exp_wdata);
        end
        if (cur_valid && done_o && cur.obs_done < 0) cur.obs_done = cyc;
        if (exp_done) begin
          if (cur.is_ld) last_rdata = cur.exp_rdata;
          if (cur.exp_exc) last_bad = cur.s.addr;
          check("exc", 32'(exc_o), 32'(cur.exp_exc));
          cur.obs_rdata = rdata_o;
          cur.obs_exc = exc_o;
          cur.obs_bad = badaddr_o;
        end else begin
          check("exc_idle", 32'(exc_o), 32'd0);
        end
        check("rdata",   rdata_o,   last_rdata);
        check("badaddr", badaddr_o, last_bad);
        if (exp_done) begin
          log_q.push_back(cur);
          cur_valid = 1'b0;
        end

        if (cur_valid && cur.s.rst_in_rd && cyc == cur.acc) begin
          // Load is in its read cycle: reset mid-access.
          rst = 1'b1;
          req_i = 1'b0;
          cur_valid = 1'b0;
          rst_check = 1;
        end else if (!cur_valid && stim_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
          s = stim_q.pop_front();
          req_i = 1'b1;
          op_i = s.op;
          addr_i = s.addr;
          wdata_i = s.wdata;
          cur = model_accept(s, cyc + 1);
          cur_valid = 1'b1;
        end else if (!cur_valid) begin
          req_i = 1'b0;
        end else begin
          // Busy: requester may keep req asserted with arbitrary contents.
          req_i = 1'($urandom_range(1));
          op_i = 6'($urandom);
          addr_i = $urandom;
          wdata_i = $urandom;
        end
      end
    end
  end

  task automatic push(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit rst_in_rd);
    stim_t s;
    s.op = op;
    s.addr = addr;
    s.wdata = wdata;
    s.rst_in_rd = rst_in_rd;
    stim_q.push_back(s);
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((stim_q.size() > 0 || cur_valid || rst_check != 0) && i < 20000) begin
      @(posedge clk);
      i++;
    end
    check(name, 32'(stim_q.size() > 0 || cur_valid), 32'd0);
  endtask

  logic [5:0] ops [9];

  initial begin
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, 6'h3F};
    for (int w = 0; w < NWORDS; w++) begin
      sram[w] = init_word(w);
      for (int b = 0; b < 4; b++) mem_ref[4*w + b] = init_word(w) >> (8 * b);
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready",   32'(ready_o),  32'd1);
    check("reset_done",    32'(done_o),   32'd0);
    check("reset_exc",     32'(exc_o),    32'd0);
    check("reset_ram_en",  32'(ram_en_o), 32'd0);
    check("reset_ram_be",  32'(ram_be_o), 32'd0);
    check("reset_rdata",   rdata_o,       32'h0);
    check("reset_badaddr", badaddr_o,     32'h0);
    check("reset_ram_addr", 32'(ram_addr_o), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    run = 1'b1;

    // Directed scenarios, issued back to back.
    push(OP_SW,  32'h10, 32'hDEADBEEF, 0);  // 0
    push(OP_LW,  32'h10, 32'h0, 0);         // 1
    push(OP_SW,  32'h10, 32'h11223344, 0);  // 2 accepted in lw's done cycle
    push(OP_SB,  32'h13, 32'h000000A5, 0);  // 3
    push(OP_LW,  32'h10, 32'h0, 0);         // 4
    push(OP_LB,  32'h13, 32'h0, 0);         // 5
    push(OP_LBU, 32'h13, 32'h0, 0);         // 6
    push(OP_SH,  32'h12, 32'h00008001, 0);  // 7
    push(OP_LH,  32'h12, 32'h0, 0);         // 8
    push(OP_LHU, 32'h12, 32'h0, 0);         // 9
    push(OP_LW,  32'h21, 32'h0, 0);         // 10
    push(6'h3F,  32'h10, 32'h0, 0);         // 11 unknown opcode
    push(OP_LW,  32'h10, 32'h0, 1);         // reset during RD, never logged
    push(OP_LW,  32'h10, 32'h0, 0);         // 12
    drain("drain_directed");

    check("log_len", 32'(log_q.size()), 32'd13);
    if (log_q.size() >= 13) begin
      // Store done appears after edge E1, load done after edge E2.
      check("sw_be",        32'(log_q[0].obs_be),   32'hF);
      check("sw_ram_addr",  32'(log_q[0].obs_addr), 32'd4);
      check("sw_done_lat",  32'(log_q[0].obs_done - log_q[0].acc), 32'd1);
      check("lw_rdata",     log_q[1].obs_rdata, 32'hDEADBEEF);
      check("lw_done_lat",  32'(log_q[1].obs_done - log_q[1].acc), 32'd2);
      check("b2b_accept",   32'(log_q[2].acc), 32'(log_q[1].obs_done + 1));
      check("b2b_wr",       32'(log_q[2].obs_en), 32'd1);
      check("sb_be",        32'(log_q[3].obs_be), 32'h8);
      check("sb_wdata",     log_q[3].obs_wdata, 32'hA5A5A5A5);
      check("lw_after_sb",  log_q[4].obs_rdata, 32'hA5223344);
      check("model_lw_sb",  log_q[4].exp_rdata, 32'hA5223344);
      check("lb_sext",      log_q[5].obs_rdata, 32'hFFFFFFA5);
      check("lbu_zext",     log_q[6].obs_rdata, 32'h000000A5);
      check("sh_be",        32'(log_q[7].obs_be), 32'hC);
      check("lh_sext",      log_q[8].obs_rdata, 32'hFFFF8001);
      check("model_lh",     log_q[8].exp_rdata, 32'hFFFF8001);
      check("lhu_zext",     log_q[9].obs_rdata, 32'h00008001);
`ifdef DMEM_MISALIGN_EXC_EN
      check("mis_no_ram",   32'(log_q[10].obs_en),  32'd0);
      check("mis_exc",      32'(log_q[10].obs_exc), 32'd1);
      check("mis_badaddr",  log_q[10].obs_bad, 32'h21);
      check("mis_done_lat", 32'(log_q[10].obs_done - log_q[10].acc), 32'd0);
`else
      check("mis_ram",      32'(log_q[10].obs_en),   32'd1);
      check("mis_addr",     32'(log_q[10].obs_addr), 32'd8);
      check("mis_exc",      32'(log_q[10].obs_exc),  32'd0);
`endif
      check("unk_no_ram",   32'(log_q[11].obs_en), 32'd0);
      check("unk_done_lat", 32'(log_q[11].obs_done - log_q[11].acc), 32'd0);
      check("lw_after_rst", log_q[12].obs_rdata, 32'h80013344);
    end

    // Randomized traffic concentrated on a small window so loads hit stores.
    gaps = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(7) == 0) ? $urandom : 32'($urandom_range(255));
      push(ops[$urandom_range(8)], a, $urandom, 0);
    end
    drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder on the memory side of the MEM-stage load/store interface. Accepts one load or store request at a time, drives a single-port synchronous SRAM with per-byte write enables, and returns load data already lane-extracted and zero- or sign-extended. Store data is lane-replicated and byte-enabled here, so the pipeline presents register-aligned data in both directions.

## Interface
- ADDR_W, 12: SRAM word-address width (depth 2^ADDR_W words)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  request valid; sampled only when ready=1
- op  in  6  MIPS opcode: lb/lh/lw/lbu/lhu/sb/sh/sw constants from def.v
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- ready  out  1  controller idle, request will be accepted
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result, valid while done=1, held until next load completes
- exc  out  1  misaligned-access flag, valid with done
- badaddr  out  32  address of last misaligned request
- ram_en  out  1  SRAM cycle enable
- ram_be  out  4  byte write enables; bit i writes ram_wdata[8i+7:8i]; 0 means read
- ram_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
- ram_wdata  out  32  lane-placed store data
- ram_rdata  in  32  SRAM read data, valid the cycle after a read cycle

## Operation
- FSM states IDLE, WR, RD, RSP. ready=1 only in IDLE.
- IDLE, req=1: capture op/addr/wdata. Store -> WR; load -> RD; misaligned (with macro) or unknown op -> stay IDLE, done=1 next cycle, no RAM access.
- WR: ram_en=1. sb: ram_be=1<<addr[1:0], wdata[7:0] replicated into all four lanes. sh: ram_be=addr[1]?4'b1100:4'b0011, wdata[15:0] replicated into both halves. sw: ram_be=4'b1111. -> IDLE, done=1.
- RD: ram_en=1, ram_be=0 -> RSP.
- RSP: select lane from ram_rdata by captured addr; lb/lh sign-extend, lbu/lhu zero-extend, lw pass-through; register into rdata -> IDLE, done=1.
- All RAM-side outputs are registered; ram_en=0 and ram_be=0 outside WR/RD.
- req while ready=0 is ignored; the requester holds req until it sees ready.
- Reset at any time, including mid-access: state IDLE; done, exc, ram_en, ram_be = 0; rdata, badaddr, ram_addr, ram_wdata = 0. An interrupted store either wrote fully in WR or did not write at all.

## Timing
- Accept edge E0. Store: WR during E0–E1, done during E1–E2.
- Load: RD during E0–E1, RSP during E1–E2, done and rdata during E2–E3.
- Back-to-back: a new request is accepted in the same cycle done is high, because state is IDLE.
- Throughput: 1 store per 2 cycles, 1 load per 3 cycles.

## Configuration
- DMEM_MISALIGN_EXC_EN defined:
  - lh/lhu/sh with addr[0]=1 are misaligned.
  - lw/sw with addr[1:0]!=0 are misaligned.
  - Misaligned request: no RAM access, done=1 and exc=1 next cycle, badaddr=addr.
- Undefined:
  - exc tied 0, badaddr tied 0.
  - Halfword ignores addr[0]; word ignores addr[1:0].
  - Every valid op performs its access.

## Structure
- def.v holds the op_* opcode constants and the FSM state encodings.
- One combinational sub-module, ld_extract: (op, addr[1:0], word) -> extended rdata. It is instantiated in RSP and unit-testable alone.

## Test plan
- sw addr=0x10, wdata=0xDEADBEEF:
  - ram_be=1111 and ram_addr=4 in WR.
  - done 2 cycles after accept.
  - Subsequent lw returns 0xDEADBEEF 3 cycles after accept.
- sb addr=0x13, wdata=0x000000A5 over word 0x11223344:
  - ram_be=1000, ram_wdata=0xA5A5A5A5.
  - lw returns 0xA5223344.
  - lb addr=0x13 -> 0xFFFFFFA5; lbu -> 0x000000A5.
- sh addr=0x12, wdata=0x8001:
  - ram_be=1100.
  - lh addr=0x12 -> 0xFFFF8001; lhu -> 0x00008001.
- lw addr=0x21 with DMEM_MISALIGN_EXC_EN: no ram_en, done=1 and exc=1 next cycle, badaddr=0x21. Without the macro: reads word 8, exc=0.
- req held high while busy: only one access issued per ready window. New sw accepted in the done cycle of a prior lw: WR follows immediately.
- rst asserted during RD: next cycle ram_en=0, done=0, ready=1; a following lw returns correct data.
